alu_vector_pipe: RTL
====================

ALU_VECTOR_PIPE -- requirements
Module: alu_vector_pipe

Interface
REQ-001 Parameter N, default 32, lane width in bits.
REQ-002 Parameter L, default 8, lane count; V = N*L is a derived localparam, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 A  input  V  operand A; lane i = A[i*N +: N].
REQ-008 B  input  V  operand B, same lane packing.
REQ-009 ALUControl  input  3  opcode, shared by all lanes.
REQ-010 lane_en  input  L  per-lane enable mask.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  V  lane results, same packing as A.
REQ-014 flags  output  4*L  lane i flags at [4*i +: 4], order {N,Z,C,V} from bit 3 to bit 0.
REQ-015 all_zero  output  1  every enabled lane has Z=1; 0 if no lane enabled.

Function
REQ-016 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLL (A << B[log2 N-1:0]), 110 SRL (logical), 111 PASS B.
REQ-017 Arithmetic is modulo 2^N per lane; no carry crosses lanes.
REQ-018 N = result MSB; Z = result==0; C = carry-out for ADD, NOT borrow for SUB (1 when A>=B unsigned), 0 for all other ops; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-019 Disabled lane: result lane = A lane unchanged, lane flags = 4'b0000.
REQ-020 Pipeline: stage 1 registers A, B, ALUControl, lane_en; stage 2 registers result, flags, all_zero.
REQ-021 Latency: a beat accepted at edge k appears on out_valid/result at edge k+2 when out_ready stays high.
REQ-022 Throughput: one beat per cycle when out_ready stays high.
REQ-023 Advance enable adv = !out_valid || out_ready; in_ready = adv (combinational).
REQ-024 Accept occurs when in_valid && in_ready; stage-1 valid loads in_valid whenever adv=1.
REQ-025 When adv=0 both stages hold all contents; result/flags stable while out_valid && !out_ready.
REQ-026 Bubbles: stage valids propagate, so in_valid gaps produce out_valid gaps in order; no beat is dropped or duplicated.
REQ-027 Beat order is preserved.
REQ-028 Data registers in invalid stages are don't-care but must not assert out_valid.

Reset
REQ-029 rst_n low clears both stage valids, out_valid=0, result=0, flags=0, all_zero=0, immediately and asynchronously.
REQ-030 Reset mid-stream discards all in-flight beats; in_ready=1 on the first cycle after rst_n deasserts.
REQ-031 Reset deassertion is synchronised externally; no internal synchroniser.

Structure
REQ-032 Package alu_vector_pkg holds the opcode enum (3-bit), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and lane-slice helper function.
REQ-033 One sub-module alu_lane (parameter N; inputs A, B, ALUControl, en; outputs result, flags), purely combinational, instantiated L times via generate.
REQ-034 all_zero reduction is computed in stage 2 logic from lane flags and the registered lane_en.

Verification
REQ-035 N=32,L=8, ADD A lanes=32'hFFFF_FFFF, B lanes=1, mask=8'hFF -> all result lanes 0, each lane flags 4'b0110, all_zero=1, out_valid two edges after accept.
REQ-036 SUB lane0 A=5,B=7 with mask=8'h01 -> lane0 result 32'hFFFF_FFFE, flags 4'b1000; lanes 1-7 result = A, flags 0.
REQ-037 ADD 32'h7FFF_FFFF + 1 in lane3 -> lane3 result 32'h8000_0000, flags 4'b1001.
REQ-038 Stream 4 beats back-to-back, hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0 while stalled, result stable, all 4 beats emerge in order, none lost.
REQ-039 Assert rst_n=0 with 2 beats in flight -> out_valid drops same cycle, outputs zero, no stale beat after release.
REQ-040 Re-run REQ-035 with L=4,N=16 and mask=0 -> result=A, flags=0, all_zero=0.

Source files
------------

// File: rtl/alu_vector_pkg.sv
// Shared definitions for the lane-parallel ALU pipeline.
//   alu_op_e    : 3-bit opcode shared by every lane
//   FLAG_*      : bit positions of {N,Z,C,V} inside a lane's 4-bit flag nibble
//   lane_base() : low bit index of a lane inside a packed vector
package alu_vector_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_SRL  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic int lane_base(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/alu_vector_pipe_lane.sv
// Single ALU lane, purely combinational.
//   A, B       : lane operands (N bits)
//   ALUControl : opcode (alu_op_e encoding)
//   en         : lane enable; a disabled lane passes A through with zero flags
//   result     : lane result (N bits)
//   flags      : {N,Z,C,V}
module alu_lane
    import alu_vector_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic [2:0]        ALUControl,
    input  logic              en,
    output logic [N-1:0]      result,
    output logic [FLAG_W-1:0] flags
);

    localparam int SH_W = (N > 1) ? $clog2(N) : 1;

    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;
    logic [N:0]          sum_ext;
    logic [N-1:0]        raw;
    logic                carry;
    logic                ovf;
    logic [SH_W-1:0]     shamt;

    assign a_s   = A;
    assign b_s   = B;
    assign shamt = B[SH_W-1:0];

    always_comb begin
        sum_ext = '0;
        raw     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (alu_op_e'(ALUControl))
            OP_ADD: begin
                sum_ext = {1'b0, A} + {1'b0, B};
                raw     = sum_ext[N-1:0];
                carry   = sum_ext[N];
                // Overflow: operands share a sign that the result does not.
                ovf     = ((a_s < 0) == (b_s < 0)) && (raw[N-1] != A[N-1]);
            end
            OP_SUB: begin
                // A + ~B + 1: carry out is the inverted borrow (1 when A >= B).
                sum_ext = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
                raw     = sum_ext[N-1:0];
                carry   = sum_ext[N];
                ovf     = ((a_s < 0) != (b_s < 0)) && (raw[N-1] != A[N-1]);
            end
            OP_AND:  raw = A & B;
            OP_OR:   raw = A | B;
            OP_XOR:  raw = A ^ B;
            OP_SLL:  raw = A << shamt;
            OP_SRL:  raw = A >> shamt;
            OP_PASS: raw = B;
            default: raw = B;
        endcase

        result = A;
        flags  = '0;
        if (en) begin
            result         = raw;
            flags[FLAG_N]  = raw[N-1];
            flags[FLAG_Z]  = (raw == '0);
            flags[FLAG_C]  = carry;
            flags[FLAG_V]  = ovf;
        end
    end

endmodule

// File: rtl/alu_vector_pipe.sv
// Two-stage, lane-parallel ALU with valid/ready flow control.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready = advance enable)
//   A, B                : L packed lanes of N bits
//   ALUControl          : opcode shared by all lanes
//   lane_en             : per-lane enable mask
//   out_valid/out_ready : result beat handshake
//   result              : L packed lane results
//   flags               : 4 bits per lane, {N,Z,C,V}
//   all_zero            : every enabled lane is zero (0 when no lane enabled)
module alu_vector_pipe
    import alu_vector_pkg::*;
#(
    parameter  int N = 32,
    parameter  int L = 8,
    localparam int V = N * L
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [V-1:0]        A,
    input  logic [V-1:0]        B,
    input  logic [2:0]          ALUControl,
    input  logic [L-1:0]        lane_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [V-1:0]        result,
    output logic [FLAG_W*L-1:0] flags,
    output logic                all_zero
);

    logic                adv;

    logic                vld_p1_q, vld_p1_d;
    logic [V-1:0]        a_p1_q, a_p1_d;
    logic [V-1:0]        b_p1_q, b_p1_d;
    logic [2:0]          op_p1_q, op_p1_d;
    logic [L-1:0]        en_p1_q, en_p1_d;

    logic                vld_p2_q, vld_p2_d;
    logic [V-1:0]        result_p2_q, result_p2_d;
    logic [FLAG_W*L-1:0] flags_p2_q, flags_p2_d;
    logic                all_zero_p2_q, all_zero_p2_d;

    logic [V-1:0]        lane_result;
    logic [FLAG_W*L-1:0] lane_flags;
    logic [L-1:0]        lane_zero;

    // ---- stage 1 -> stage 2 boundary: lane ALUs on registered operands ----
    for (genvar i = 0; i < L; i++) begin : g_lane
        alu_lane #(.N(N)) u_lane (
            .A          (a_p1_q[lane_base(i, N) +: N]),
            .B          (b_p1_q[lane_base(i, N) +: N]),
            .ALUControl (op_p1_q),
            .en         (en_p1_q[i]),
            .result     (lane_result[lane_base(i, N) +: N]),
            .flags      (lane_flags[lane_base(i, FLAG_W) +: FLAG_W])
        );
        assign lane_zero[i] = lane_flags[lane_base(i, FLAG_W) + FLAG_Z];
    end

    // Whole pipe moves together: a stalled output freezes both stages.
    assign adv      = !vld_p2_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_p1_d      = vld_p1_q;
        a_p1_d        = a_p1_q;
        b_p1_d        = b_p1_q;
        op_p1_d       = op_p1_q;
        en_p1_d       = en_p1_q;
        vld_p2_d      = vld_p2_q;
        result_p2_d   = result_p2_q;
        flags_p2_d    = flags_p2_q;
        all_zero_p2_d = all_zero_p2_q;
        if (adv) begin
            vld_p1_d      = in_valid;
            a_p1_d        = A;
            b_p1_d        = B;
            op_p1_d       = ALUControl;
            en_p1_d       = lane_en;
            vld_p2_d      = vld_p1_q;
            result_p2_d   = lane_result;
            flags_p2_d    = lane_flags;
            // Disabled lanes are ignored; an empty mask never reports all-zero.
            all_zero_p2_d = (|en_p1_q) && (&(~en_p1_q | lane_zero));
        end
    end

    // ---- input -> stage 1 boundary ----
    always_ff @(posedge clk) begin
        a_p1_q  <= a_p1_d;
        b_p1_q  <= b_p1_d;
        op_p1_q <= op_p1_d;
        en_p1_q <= en_p1_d;
    end

    // ---- stage 1 -> stage 2 boundary (valids and visible outputs reset) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            result_p2_q   <= '0;
            flags_p2_q    <= '0;
            all_zero_p2_q <= 1'b0;
        end else begin
            vld_p1_q      <= vld_p1_d;
            vld_p2_q      <= vld_p2_d;
            result_p2_q   <= result_p2_d;
            flags_p2_q    <= flags_p2_d;
            all_zero_p2_q <= all_zero_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign result    = result_p2_q;
    assign flags     = flags_p2_q;
    assign all_zero  = all_zero_p2_q;

endmodule
